// File: rtl/ceres_rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// ceres_param
//   Shared types and default constants for the CERES reset sequencer.
//   - rst_seq_state_e : sequencer FSM states
//   - rst_cause_e     : encodings reported on rst_cause_o
//   - *_DEF           : default cycle counts for the sequencer parameters
// ----------------------------------------------------------------------------
package ceres_param;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_e;

    typedef enum logic [1:0] {
        RST_CAUSE_EXT  = 2'b00,
        RST_CAUSE_LOCK = 2'b01,
        RST_CAUSE_WDT  = 2'b10,
        RST_CAUSE_RSVD = 2'b11
    } rst_cause_e;

    localparam int unsigned LOCK_STABLE_CYC_DEF  = 1024;
    localparam int unsigned RST_HOLD_CYC_DEF     = 64;
    localparam int unsigned PERIPH_DELAY_CYC_DEF = 16;

endpackage

// File: rtl/ceres_sync_2ff.sv
// ----------------------------------------------------------------------------
// ceres_sync_2ff
//   Two-flop synchronizer for signals asynchronous to clk_i. Output follows
//   the input with two clock edges of latency. Both flops clear on rst_i.
//
// Ports
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input bus (WIDTH bits, each bit independent)
//   q_o   : synchronized output
// ----------------------------------------------------------------------------
module ceres_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            // p0: metastability capture; p1: settled copy
            sync_p0 <= d_i;
            sync_p1 <= sync_p0;
        end
    end

    assign q_o = sync_p1;

endmodule

// File: rtl/ceres_rst_seq.sv
// ----------------------------------------------------------------------------
// ceres_rst_seq
//   Power-on / PLL-lock reset sequencer. Waits for a stable PLL lock, holds
//   both resets for a fixed time, releases the peripheral reset, then the
//   core reset after a further delay. Lock loss restarts the whole sequence;
//   a watchdog request (optional) re-runs the hold/release part only.
//
// Configuration
//   CERES_RST_SEQ_WDT_EN : when defined, a rising edge on wdt_reset_i in RUN
//                          triggers a watchdog reset. When undefined the port
//                          is present but ignored.
//
// Parameters (a value of 0 behaves as 1)
//   LOCK_STABLE_CYC  : consecutive synchronized-lock cycles before release
//   RST_HOLD_CYC     : cycles both resets stay asserted after lock
//   PERIPH_DELAY_CYC : cycles between peripheral and core reset release
//
// Ports
//   clk_i         : PLL output clock
//   rst_i         : asynchronous active-high reset
//   locked_i      : PLL lock, asynchronous to clk_i
//   wdt_reset_i   : watchdog reset request (level, clk_i domain)
//   periph_rst_no : peripheral reset, active-low
//   core_rst_no   : core reset, active-low
//   rst_cause_o   : last reset cause (00 ext, 01 lock loss, 10 watchdog)
//   seq_busy_o    : high whenever the sequencer is not in RUN
// ----------------------------------------------------------------------------
module ceres_rst_seq
    import ceres_param::*;
#(
    parameter int unsigned LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int unsigned RST_HOLD_CYC     = RST_HOLD_CYC_DEF,
    parameter int unsigned PERIPH_DELAY_CYC = PERIPH_DELAY_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       wdt_reset_i,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic [1:0] rst_cause_o,
    output logic       seq_busy_o
);

    function automatic int unsigned clamp_min1(input int unsigned v);
        return (v == 0) ? 32'd1 : v;
    endfunction

    localparam int unsigned LOCK_EFF = clamp_min1(LOCK_STABLE_CYC);
    localparam int unsigned HOLD_EFF = clamp_min1(RST_HOLD_CYC);
    localparam int unsigned PER_EFF  = clamp_min1(PERIPH_DELAY_CYC);

    localparam int unsigned MAX_CYC =
        (LOCK_EFF > HOLD_EFF) ? ((LOCK_EFF > PER_EFF) ? LOCK_EFF : PER_EFF)
                              : ((HOLD_EFF > PER_EFF) ? HOLD_EFF : PER_EFF);

    // One extra bit of headroom; the counter never exceeds MAX_CYC-1.
    localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PER_EFF - 1);

    rst_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rst_cause_e       cause_q, cause_d;
    logic             periph_rst_n_d;
    logic             core_rst_n_d;
    logic             busy_d;
    logic             locked_s;
    logic             wdt_evt;

    ceres_sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (locked_i),
        .q_o   (locked_s)
    );

`ifdef CERES_RST_SEQ_WDT_EN
    logic wdt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_q <= 1'b0;
        end else begin
            wdt_q <= wdt_reset_i;
        end
    end

    // Rising edge only: a request held high cannot retrigger after release.
    assign wdt_evt = wdt_reset_i & ~wdt_q;
`else
    logic unused_wdt;

    assign unused_wdt = wdt_reset_i;
    assign wdt_evt    = 1'b0;
`endif

    // Next-state, counter and cause decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        unique case (state_q)
            WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = RST_CAUSE_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PERIPH: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = RST_CAUSE_LOCK;
                end else if (cnt_q == PER_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                // Lock loss is checked first so it wins over a watchdog event.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = RST_CAUSE_LOCK;
                end else if (wdt_evt) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    cause_d = RST_CAUSE_WDT;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge the state is entered.
    always_comb begin
        periph_rst_n_d = (state_d == PERIPH) || (state_d == RUN);
        core_rst_n_d   = (state_d == RUN);
        busy_d         = (state_d != RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            cause_q       <= RST_CAUSE_EXT;
            periph_rst_no <= 1'b0;
            core_rst_no   <= 1'b0;
            seq_busy_o    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cause_q       <= cause_d;
            periph_rst_no <= periph_rst_n_d;
            core_rst_no   <= core_rst_n_d;
            seq_busy_o    <= busy_d;
        end
    end

    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_ceres_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_ceres_rst_seq
//   Directed bench for ceres_rst_seq with LOCK_STABLE_CYC=8, RST_HOLD_CYC=4,
//   PERIPH_DELAY_CYC=2. Stimulus queues each expected output change together
//   with the clock edge it must appear on; a monitor compares every observed
//   change of {periph_rst_no, core_rst_no, rst_cause_o, seq_busy_o} against
//   the head of that queue.
// ----------------------------------------------------------------------------
module tb_ceres_rst_seq;

    localparam int unsigned LOCK = 8;
    localparam int unsigned HOLD = 4;
    localparam int unsigned PER  = 2;

    typedef struct {
        int         cyc;
        logic       p;
        logic       c;
        logic [1:0] cause;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       wdt;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic [1:0] cause;
    logic       busy;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t e;
    logic mon_en = 1'b0;
    logic [4:0] prev;
    logic [4:0] now_v;

    ceres_rst_seq #(
        .LOCK_STABLE_CYC  (LOCK),
        .RST_HOLD_CYC     (HOLD),
        .PERIPH_DELAY_CYC (PER)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .locked_i      (locked),
        .wdt_reset_i   (wdt),
        .periph_rst_no (periph_rst_n),
        .core_rst_no   (core_rst_n),
        .rst_cause_o   (cause),
        .seq_busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_chg(input int at, input logic p, input logic c,
                              input logic [1:0] ca, input logic b);
        exp_t n;
        n = '{cyc: at, p: p, c: c, cause: ca, busy: b};
        exp_q.push_back(n);
    endtask

    task automatic check_now(input string name, input logic p, input logic c,
                             input logic [1:0] ca, input logic b);
        vectors++;
        if ({periph_rst_n, core_rst_n, cause, busy} !== {p, c, ca, b}) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got p=%b c=%b cause=%b busy=%b, want p=%b c=%b cause=%b busy=%b",
                     name, cyc, periph_rst_n, core_rst_n, cause, busy, p, c, ca, b);
        end
    endtask

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            now_v = {periph_rst_n, core_rst_n, cause, busy};
            if (now_v !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change @cyc %0d: got {p,c,cause,busy}=%b, want unchanged %b",
                             cyc, now_v, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || now_v !== {e.p, e.c, e.cause, e.busy}) begin
                        miscompares++;
                        $display("FAIL output_change: got %b @cyc %0d, want %b @cyc %0d",
                                 now_v, cyc, {e.p, e.c, e.cause, e.busy}, e.cyc);
                    end
                end
                prev = now_v;
            end
        end
    end

    initial begin
        int         base;
        int         r;
        int         s;
        int         w;
        logic [1:0] cause_now;

        rst    = 1'b1;
        locked = 1'b1;
        wdt    = 1'b0;
        tick(3);
        check_now("reset_state", 1'b0, 1'b0, 2'b00, 1'b1);
        prev   = {periph_rst_n, core_rst_n, cause, busy};
        mon_en = 1'b1;

        // Cold start: lock qualified after 8 synced cycles, then 4 + 2.
        rst  = 1'b0;
        base = cyc;
        expect_chg(base + 14, 1'b1, 1'b0, 2'b00, 1'b1);
        expect_chg(base + 16, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(8);
        check_now("cold_wait_lock", 1'b0, 1'b0, 2'b00, 1'b1);
        tick(12);
        check_now("cold_run", 1'b1, 1'b1, 2'b00, 1'b0);

        // One-cycle lock loss in RUN.
        r = cyc;
        expect_chg(r + 3,  1'b0, 1'b0, 2'b01, 1'b1);
        expect_chg(r + 15, 1'b1, 1'b0, 2'b01, 1'b1);
        expect_chg(r + 17, 1'b1, 1'b1, 2'b01, 1'b0);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(3);
        check_now("lockloss_reset", 1'b0, 1'b0, 2'b01, 1'b1);
        tick(16);
        check_now("lockloss_rerun", 1'b1, 1'b1, 2'b01, 1'b0);

        // Lock glitch during WAIT_LOCK at count 5: release delayed by 3 + 5.
        r = cyc;
        s = r + 5;
        expect_chg(r + 3,  1'b0, 1'b0, 2'b01, 1'b1);
        expect_chg(s + 22, 1'b1, 1'b0, 2'b01, 1'b1);
        expect_chg(s + 24, 1'b1, 1'b1, 2'b01, 1'b0);
        locked = 1'b0;
        tick(5);
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(12);
        check_now("glitch_still_held", 1'b0, 1'b0, 2'b01, 1'b1);
        tick(6);
        check_now("glitch_run", 1'b1, 1'b1, 2'b01, 1'b0);

        // Watchdog request held high in RUN.
        w = cyc;
`ifdef CERES_RST_SEQ_WDT_EN
        cause_now = 2'b10;
        expect_chg(w + 1, 1'b0, 1'b0, 2'b10, 1'b1);
        expect_chg(w + 5, 1'b1, 1'b0, 2'b10, 1'b1);
        expect_chg(w + 7, 1'b1, 1'b1, 2'b10, 1'b0);
`else
        cause_now = 2'b01;
`endif
        wdt = 1'b1;
        tick(100);
        check_now("wdt_after_100", 1'b1, 1'b1, cause_now, 1'b0);
        wdt = 1'b0;
        tick(5);

        // Async reset in PERIPH: outputs must drop without a clock edge.
        r = cyc;
        expect_chg(r + 3,  1'b0, 1'b0, 2'b01, 1'b1);
        expect_chg(r + 15, 1'b1, 1'b0, 2'b01, 1'b1);
        expect_chg(r + 16, 1'b0, 1'b0, 2'b00, 1'b1);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(14);
        check_now("periph_state", 1'b1, 1'b0, 2'b01, 1'b1);
        #6;
        rst = 1'b1;
        #1;
        check_now("async_rst_periph", 1'b0, 1'b0, 2'b00, 1'b1);
        tick(3);
        check_now("rst_held", 1'b0, 1'b0, 2'b00, 1'b1);

        // Full sequence after the external reset.
        rst  = 1'b0;
        base = cyc;
        expect_chg(base + 14, 1'b1, 1'b0, 2'b00, 1'b1);
        expect_chg(base + 16, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(20);
        check_now("restart_run", 1'b1, 1'b1, 2'b00, 1'b0);

        tick(2);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_changes: got %0d unseen expected changes, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ceres_rst_seq.md
CERES_RST_SEQ -- requirements
Module: ceres_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized-locked cycles required before the reset release sequence starts.
REQ-002 SHALL have parameter RST_HOLD_CYC, default 64: cycles both resets stay asserted after lock is qualified.
REQ-003 SHALL have parameter PERIPH_DELAY_CYC, default 16: cycles peripheral reset is released before core reset.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, the PLL output clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port locked_i, input, 1 bit: PLL lock, asynchronous to clk_i.
REQ-007 SHALL have port wdt_reset_i, input, 1 bit: watchdog reset request, level, clk_i domain.
REQ-008 SHALL have port periph_rst_no, output, 1 bit: peripheral reset, active-low.
REQ-009 SHALL have port core_rst_no, output, 1 bit: CPU/core reset, active-low; drives the core wrapper's rst_ni.
REQ-010 SHALL have port rst_cause_o, output, 2 bits: last reset cause (00 external/power-on, 01 lock loss, 10 watchdog, 11 reserved).
REQ-011 SHALL have port seq_busy_o, output, 1 bit: high in every state except RUN.

Function
REQ-012 SHALL pass locked_i through a two-flop synchronizer to locked_s (2-edge latency).
REQ-013 SHALL implement FSM states WAIT_LOCK, HOLD, PERIPH and RUN.
REQ-014 WAIT_LOCK: counter increments each cycle locked_s=1 and clears when locked_s=0; after LOCK_STABLE_CYC consecutive high cycles -> HOLD.
REQ-015 HOLD: after exactly RST_HOLD_CYC cycles -> PERIPH.
REQ-016 PERIPH: after exactly PERIPH_DELAY_CYC cycles -> RUN.
REQ-017 RUN: remain until a lock-loss or watchdog event occurs.
REQ-018 Outputs SHALL be registered from next-state decode, so each output changes on the same edge the state is entered.
REQ-019 Output decode: periph_rst_no=1 in PERIPH and RUN; core_rst_no=1 in RUN only; both 0 otherwise.
REQ-020 locked_s=0 in HOLD, PERIPH or RUN SHALL go to WAIT_LOCK on the next edge, assert both resets, clear the counter and set rst_cause_o=01.
REQ-021 Watchdog event (REQ-029) in RUN SHALL go to HOLD, assert both resets and set rst_cause_o=10.
REQ-022 Watchdog requests outside RUN SHALL be ignored.
REQ-023 Lock loss takes priority over a simultaneous watchdog event.
REQ-024 A single shared down/up counter SHALL be used, sized $clog2 of the largest parameter plus 1, and reloaded on every state entry; no wrap-around SHALL be possible.
REQ-025 Parameters of value 0 SHALL be treated as 1.

Reset
REQ-026 rst_i=1 SHALL asynchronously force: state WAIT_LOCK, counter 0, synchronizer flops 0, periph_rst_no=0, core_rst_no=0, rst_cause_o=00, seq_busy_o=1.
REQ-027 Reset asserted mid-sequence or in RUN SHALL restart the full sequence from WAIT_LOCK.
REQ-028 rst_cause_o SHALL retain its value across lock-loss and watchdog sequences and be cleared only by rst_i.

Configuration
REQ-029 Macro CERES_RST_SEQ_WDT_EN defined: wdt_reset_i is registered once, and a watchdog event is its rising edge.
REQ-030 Macro CERES_RST_SEQ_WDT_EN undefined: wdt_reset_i is ignored, no flop is inferred, and rst_cause_o never reads 10; the port remains present.

Structure
REQ-031 Package ceres_param SHALL hold the typedef rst_seq_state_e, the rst_cause_e encodings (RST_CAUSE_EXT, RST_CAUSE_LOCK, RST_CAUSE_WDT) and the default cycle constants.
REQ-032 The synchronizer SHALL be a sub-module ceres_sync_2ff (WIDTH parameter, async active-high reset), instantiated once.

Verification (LOCK_STABLE_CYC=8, RST_HOLD_CYC=4, PERIPH_DELAY_CYC=2)
REQ-033 Cold start: rst_i released with locked_i=1 -> periph_rst_no rises at the 14th rising edge after release; core_rst_no rises at the 16th; seq_busy_o falls with core_rst_no; rst_cause_o=00.
REQ-034 Lock glitch: locked_i dropped for 3 cycles during WAIT_LOCK at count 5 -> counter restarts; release is delayed by those cycles plus 5; resets stay 0 throughout.
REQ-035 Lock loss in RUN: locked_i=0 for 1 cycle -> both resets go 0 within 3 edges; rst_cause_o=01; full re-sequence follows.
REQ-036 Watchdog with macro defined: wdt_reset_i pulse in RUN -> both resets go 0, rst_cause_o=10; periph released after 4 cycles, core after 2 more; lock counter not rerun.
REQ-037 Watchdog with macro undefined: wdt_reset_i held high in RUN -> no change on any output for 100 cycles.
REQ-038 Async reset mid-PERIPH: rst_i pulse asserted between edges -> periph_rst_no=0 immediately (no clock edge needed); rst_cause_o=00.
